// File: rtl/uart_pkg.sv
// Shared definitions for uart_core: parity encodings, FSM state types and
// the frame-length helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  // Total bits on the wire for one frame, start bit included.
  function automatic int nbits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_core_if.sv
// Host-side signal bundle of uart_core: TX handshake, serial pins and RX results.
interface uart_core_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx;
  logic       rx;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_busy;

  modport master (
    output tx_valid, tx_data, rx,
    input  tx_ready, tx, rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_busy
  );

  modport slave (
    input  tx_valid, tx_data, rx,
    output tx_ready, tx, rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_busy
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: full_tick on the last cycle of each bit, half_tick at mid-bit.
// The count wraps to zero on full_tick so it never passes CLKS_PER_BIT-1.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic nRst,
  input  logic clr,
  input  logic en,
  output logic half_tick,
  output logic full_tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] r_cnt;

  assign full_tick = en && (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign half_tick = en && (r_cnt == CW'(CLKS_PER_BIT / 2 - 1));

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_cnt <= '0;
    end else if (clr || full_tick) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart_core.sv
// Parametrised full-duplex UART: valid/ready transmitter and a synchronised
// receiver with glitch rejection, parity and framing checks.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input logic        clk,
  input logic        nRst,
  uart_core_if.slave bus
);
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  function automatic logic par_bit(input logic [7:0] d);
    return (PARITY == PAR_EVEN) ? ^d : ~^d;
  endfunction

  tx_state_t  r_tx_state, w_tx_state_next;
  logic [7:0] r_tx_shift, w_tx_shift_next;
  logic [2:0] r_tx_idx, w_tx_idx_next;
  logic       r_tx_par, w_tx_par_next;
  logic       r_tx, w_tx_next;
  logic       w_tx_clr, w_tx_full, w_tx_half_unused, w_tx_ready, w_tx_accept;

  assign w_tx_clr    = (r_tx_state == TX_IDLE);
  // Ready in the last stop cycle lets the next start bit follow with no gap.
  assign w_tx_ready  = (r_tx_state == TX_IDLE) ||
                       ((r_tx_state == TX_STOP) && (r_tx_idx == STOP_LAST) && w_tx_full);
  assign w_tx_accept = bus.tx_valid && w_tx_ready;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk(clk), .nRst(nRst), .clr(w_tx_clr), .en(!w_tx_clr),
    .half_tick(w_tx_half_unused), .full_tick(w_tx_full)
  );

  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_shift_next = r_tx_shift;
    w_tx_idx_next   = r_tx_idx;
    w_tx_par_next   = r_tx_par;
    w_tx_next       = r_tx;
    case (r_tx_state)
      TX_IDLE: w_tx_next = 1'b1;
      TX_START: if (w_tx_full) begin
        w_tx_state_next = TX_DATA;
        w_tx_idx_next   = '0;
        w_tx_next       = r_tx_shift[0];
      end
      TX_DATA: if (w_tx_full) begin
        if (r_tx_idx == DATA_LAST) begin
          w_tx_idx_next = '0;
          if (PARITY != PAR_NONE) begin
            w_tx_state_next = TX_PARITY;
            w_tx_next       = r_tx_par;
          end else begin
            w_tx_state_next = TX_STOP;
            w_tx_next       = 1'b1;
          end
        end else begin
          w_tx_idx_next   = r_tx_idx + 3'd1;
          w_tx_shift_next = r_tx_shift >> 1;
          w_tx_next       = r_tx_shift[1];
        end
      end
      TX_PARITY: if (w_tx_full) begin
        w_tx_state_next = TX_STOP;
        w_tx_next       = 1'b1;
      end
      TX_STOP: if (w_tx_full) begin
        if (r_tx_idx == STOP_LAST) w_tx_state_next = TX_IDLE;
        else                       w_tx_idx_next   = r_tx_idx + 3'd1;
      end
      default: w_tx_state_next = TX_IDLE;
    endcase
    if (w_tx_accept) begin
      w_tx_state_next = TX_START;
      w_tx_shift_next = bus.tx_data & DATA_MASK;
      w_tx_par_next   = par_bit(bus.tx_data & DATA_MASK);
      w_tx_next       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_tx_state <= TX_IDLE;
      r_tx_shift <= '0;
      r_tx_idx   <= '0;
      r_tx_par   <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_tx_shift <= w_tx_shift_next;
      r_tx_idx   <= w_tx_idx_next;
      r_tx_par   <= w_tx_par_next;
      r_tx       <= w_tx_next;
    end
  end

  assign bus.tx       = r_tx;
  assign bus.tx_ready = w_tx_ready;

  logic       r_rx_meta, r_rs;
  rx_state_t  r_rx_state, w_rx_state_next;
  logic [7:0] r_rx_shift, w_rx_shift_next, w_rx_word;
  logic [2:0] r_rx_idx, w_rx_idx_next;
  logic       r_rx_pbad, w_rx_pbad_next;
  logic       r_rx_valid, w_rx_valid_next;
  logic [7:0] r_rx_data, w_rx_data_next;
  logic       r_rx_perr, w_rx_perr_next, r_rx_ferr, w_rx_ferr_next;
  logic       w_rx_clr, w_rx_en, w_rx_half, w_rx_full;

  // Samples enter at the top, so a short word ends up left-aligned.
  assign w_rx_word = r_rx_shift >> (8 - DATA_BITS);
  assign w_rx_en   = r_rx_state inside {RX_START, RX_DATA, RX_PARITY, RX_STOP};

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk(clk), .nRst(nRst), .clr(w_rx_clr), .en(w_rx_en),
    .half_tick(w_rx_half), .full_tick(w_rx_full)
  );

  always_comb begin
    w_rx_state_next = r_rx_state;
    w_rx_shift_next = r_rx_shift;
    w_rx_idx_next   = r_rx_idx;
    w_rx_pbad_next  = r_rx_pbad;
    w_rx_valid_next = 1'b0;
    w_rx_data_next  = r_rx_data;
    w_rx_perr_next  = r_rx_perr;
    w_rx_ferr_next  = r_rx_ferr;
    w_rx_clr        = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_clr = 1'b1;
        if (!r_rs) w_rx_state_next = RX_START;
      end
      RX_START: if (w_rx_half) begin
        if (r_rs) begin
          w_rx_state_next = RX_IDLE;
        end else begin
          // Restart the count here so later full ticks land mid-bit.
          w_rx_state_next = RX_DATA;
          w_rx_clr        = 1'b1;
          w_rx_idx_next   = '0;
          w_rx_pbad_next  = 1'b0;
        end
      end
      RX_DATA: if (w_rx_full) begin
        w_rx_shift_next = {r_rs, r_rx_shift[7:1]};
        w_rx_idx_next   = r_rx_idx + 3'd1;
        if (r_rx_idx == DATA_LAST) begin
          if (PARITY != PAR_NONE) w_rx_state_next = RX_PARITY;
          else                    w_rx_state_next = RX_STOP;
        end
      end
      RX_PARITY: if (w_rx_full) begin
        w_rx_pbad_next  = (r_rs != par_bit(w_rx_word));
        w_rx_state_next = RX_STOP;
      end
      RX_STOP: if (w_rx_full) begin
        w_rx_valid_next = 1'b1;
        w_rx_data_next  = w_rx_word;
        w_rx_perr_next  = r_rx_pbad;
        w_rx_ferr_next  = !r_rs;
        if (r_rs) w_rx_state_next = RX_IDLE;
        else      w_rx_state_next = RX_BREAK;
      end
      RX_BREAK: begin
        w_rx_clr = 1'b1;
        if (r_rs) w_rx_state_next = RX_IDLE;
      end
      default: w_rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_rx_meta  <= 1'b1;
      r_rs       <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_shift <= '0;
      r_rx_idx   <= '0;
      r_rx_pbad  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_rx_perr  <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_meta  <= bus.rx;
      r_rs       <= r_rx_meta;
      r_rx_state <= w_rx_state_next;
      r_rx_shift <= w_rx_shift_next;
      r_rx_idx   <= w_rx_idx_next;
      r_rx_pbad  <= w_rx_pbad_next;
      r_rx_valid <= w_rx_valid_next;
      r_rx_data  <= w_rx_data_next;
      r_rx_perr  <= w_rx_perr_next;
      r_rx_ferr  <= w_rx_ferr_next;
    end
  end

  assign bus.rx_valid      = r_rx_valid;
  assign bus.rx_data       = r_rx_data;
  assign bus.rx_parity_err = r_rx_perr;
  assign bus.rx_frame_err  = r_rx_ferr;
  assign bus.rx_busy       = (r_rx_state != RX_IDLE);
endmodule
